// File: rtl/instr_fetch_if.sv
// Fetch-to-ROM / fetch-to-decode bus bundle for instr_fetch_unit.
//
// Signals:
//   start         - one-cycle pulse that starts fetching from the reset PC
//   pc_address    - ROM address, combinational copy of the program counter
//   rom_dout      - ROM data for pc_address, same cycle
//   instr_out     - registered instruction word presented to decode
//   instr_pc      - PC the presented instruction was fetched from
//   instr_valid   - instr_out holds an unconsumed instruction
//   instr_ready   - decode accepts instr_out when instr_valid is high
//   branch_taken  - one-cycle redirect request from downstream
//   branch_target - redirect address
//   halted        - fetch unit is parked in HALTED
//   pc_fault      - PC overflow trap flag
//
// Modports: master = fetch unit side, slave = ROM/decode/control side.
interface instr_fetch_if #(
  parameter int PC_WIDTH    = 5,
  parameter int INSTR_WIDTH = 59
);
  logic                   start;
  logic [PC_WIDTH-1:0]    pc_address;
  logic [INSTR_WIDTH-1:0] rom_dout;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic                   halted;
  logic                   pc_fault;

  modport master (
    input  start, rom_dout, instr_ready, branch_taken, branch_target,
    output pc_address, instr_out, instr_pc, instr_valid, halted, pc_fault
  );

  modport slave (
    output start, rom_dout, instr_ready, branch_taken, branch_target,
    input  pc_address, instr_out, instr_pc, instr_valid, halted, pc_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer sitting directly upstream of the instruction ROM.
// Owns the program counter, drives the ROM address combinationally, and
// captures the returned word into a one-entry output register that is
// handed to decode with a valid/ready handshake. Handles branch redirects
// and parks in HALTED when a HALT opcode is captured.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - instr_fetch_if.master (ROM address/data, decode handshake,
//         start, branch redirect, halted, pc_fault)
//
// Optional feature: define IFETCH_PC_WRAP_TRAP_EN to trap instead of
// wrapping when an instruction is loaded from the all-ones PC. Without it
// the PC wraps silently and pc_fault is tied low.
module instr_fetch_unit #(
  parameter int                        PC_WIDTH     = 5,
  parameter int                        INSTR_WIDTH  = 59,
  parameter logic [PC_WIDTH-1:0]       RESET_PC     = '0,
  parameter int                        OPCODE_WIDTH = 6,
  parameter logic [OPCODE_WIDTH-1:0]   HALT_OPCODE  = OPCODE_WIDTH'(6'h3F)
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    pc_reg, pc_nxt;
  logic [PC_WIDTH-1:0]    instr_pc_reg, instr_pc_nxt;
  logic [INSTR_WIDTH-1:0] instr_reg, instr_nxt;
  logic                   valid_reg, valid_nxt;
  logic                   load;
  logic                   halt_op;
`ifdef IFETCH_PC_WRAP_TRAP_EN
  logic                   fault_reg, fault_nxt;
  logic                   pc_at_max;

  assign pc_at_max = &pc_reg;
`endif

  // The output register can take a new word when it is empty or being drained.
  assign load    = !valid_reg || bus.instr_ready;
  assign halt_op = (bus.rom_dout[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_reg;
    instr_pc_nxt = instr_pc_reg;
    instr_nxt    = instr_reg;
    valid_nxt    = valid_reg;
`ifdef IFETCH_PC_WRAP_TRAP_EN
    fault_nxt    = fault_reg;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          pc_nxt    = RESET_PC;
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        // A word delivered before halting can still be drained by decode.
        if (valid_reg && bus.instr_ready) valid_nxt = 1'b0;
        if (bus.start) begin
          pc_nxt    = RESET_PC;
          state_nxt = FETCH;
`ifdef IFETCH_PC_WRAP_TRAP_EN
          fault_nxt = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (bus.branch_taken) begin
          // Redirect flushes the held word even if decode is taking it now.
          pc_nxt    = bus.branch_target;
          valid_nxt = 1'b0;
        end else if (load) begin
          instr_nxt    = bus.rom_dout;
          instr_pc_nxt = pc_reg;
          valid_nxt    = 1'b1;
`ifdef IFETCH_PC_WRAP_TRAP_EN
          if (pc_at_max) begin
            state_nxt = HALTED;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt = pc_reg + 1'b1;
          end
`else
          pc_nxt = pc_reg + 1'b1;
`endif
          if (halt_op) state_nxt = HALTED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc_reg       <= RESET_PC;
      instr_pc_reg <= '0;
      instr_reg    <= '0;
      valid_reg    <= 1'b0;
`ifdef IFETCH_PC_WRAP_TRAP_EN
      fault_reg    <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      pc_reg       <= pc_nxt;
      instr_pc_reg <= instr_pc_nxt;
      instr_reg    <= instr_nxt;
      valid_reg    <= valid_nxt;
`ifdef IFETCH_PC_WRAP_TRAP_EN
      fault_reg    <= fault_nxt;
`endif
    end
  end

  assign bus.pc_address  = pc_reg;
  assign bus.instr_out   = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.halted      = (state == HALTED);
`ifdef IFETCH_PC_WRAP_TRAP_EN
  assign bus.pc_fault    = fault_reg;
`else
  assign bus.pc_fault    = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch sequencer directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address combinationally.
- Captures the returned 59-bit instruction word into a one-entry output register, with a valid/ready handshake to the decode stage.
- Handles branch redirects from downstream and stops fetching on a HALT opcode.

Parameters:
- PC_WIDTH, 5, width of the program counter and of the ROM address.
- INSTR_WIDTH, 59, width of the instruction word.
- RESET_PC, 0, PC loaded on reset and on start.
- OPCODE_WIDTH, 6, number of instruction MSBs that form the opcode.
- HALT_OPCODE, 6'h3F, opcode value that stops fetching.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins fetching from RESET_PC when in IDLE or HALTED.
- pc_address  output  PC_WIDTH  ROM address; equals pc_reg combinationally.
- rom_dout  input  INSTR_WIDTH  ROM data, valid in the same cycle as pc_address.
- instr_out  output  INSTR_WIDTH  registered instruction.
- instr_pc  output  PC_WIDTH  PC that instr_out was fetched from.
- instr_valid  output  1  instr_out holds an unconsumed instruction.
- instr_ready  input  1  decode accepts instr_out when instr_valid is also 1.
- branch_taken  input  1  one-cycle redirect request from downstream.
- branch_target  input  PC_WIDTH  redirect address.
- halted  output  1  high while in HALTED.
- pc_fault  output  1  PC overflow trap (see Optional Feature).

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst has priority over every other input.
  - On reset: state=IDLE, pc_reg=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, halted=0, pc_fault=0.
  - Reset asserted mid-operation discards any held instruction; there is no other side effect.
- States: IDLE, FETCH, HALTED.
- IDLE:
  - No fetch.
  - start: pc_reg<=RESET_PC, go to FETCH.
  - branch_taken is ignored.
- HALTED:
  - halted=1, no fetch.
  - start: pc_reg<=RESET_PC, halted<=0, go to FETCH.
  - branch_taken is ignored.
  - A held instruction stays valid until consumed.
- FETCH, with load = (!instr_valid || instr_ready):
  - If branch_taken (highest priority):
    - pc_reg<=branch_target, instr_valid<=0.
    - The held instruction is flushed even if instr_ready=1 in that cycle.
    - No capture occurs that cycle.
  - Else if load:
    - instr_out<=rom_dout, instr_pc<=pc_reg, instr_valid<=1.
    - pc_reg<=pc_reg+1 modulo 2^PC_WIDTH, so max wraps to 0.
  - Else (stall): all state holds; pc_address stays stable.
  - HALT capture: if a load captures an instruction whose rom_dout[INSTR_WIDTH-1 -: OPCODE_WIDTH]==HALT_OPCODE, go to HALTED next cycle. That instruction is still presented with instr_valid=1.
  - Branch wins over HALT: if branch_taken occurs in the same cycle that a HALT would be captured, there is no capture and the block stays in FETCH.
- Latency:
  - First valid instruction appears 1 cycle after entering FETCH, i.e. 2 cycles after the start pulse.
  - Redirect: target instruction is valid 2 cycles after the branch_taken cycle.
- Throughput: one instruction per cycle while instr_ready=1.
- Handshake: instr_out and instr_pc are stable while instr_valid=1 and instr_ready=0.

Optional Feature:
- Macro: IFETCH_PC_WRAP_TRAP_EN.
- Defined:
  - A load with pc_reg at the all-ones value captures that instruction normally.
  - Next state is HALTED, pc_fault<=1, and pc_reg does not wrap.
  - pc_fault is cleared only by rst or start.
- Undefined: the PC wraps to 0 silently and pc_fault is tied to 0.

Test Plan:
- Reset then start, ROM[0..3]=A,B,C,D, instr_ready=1 -> pc_address 0,1,2,3 on consecutive cycles; instr_valid rises 2 cycles after start; instr_out/instr_pc = A/0, B/1, C/2, D/3 on consecutive cycles.
- Backpressure: instr_ready=0 for 3 cycles while holding B at pc 1 -> instr_out=B, instr_pc=1 and pc_address=2 stable for all 3 cycles; C follows on the cycle after ready returns.
- Branch: branch_taken=1 with target 17 while instr_valid=1 and instr_ready=1 -> instr_valid=0 next cycle; instruction from pc 17 is valid 2 cycles after the branch.
- HALT: ROM[5] opcode 6'h3F -> instruction at pc 5 is delivered with valid; halted=1; pc_address stays 6; no further captures; a later start restarts at pc 0.
- Wrap: branch to 31 then run -> without the macro, pcs 31 then 0; with IFETCH_PC_WRAP_TRAP_EN, pc 31 is delivered, then halted=1 and pc_fault=1.
- Reset mid-stream (rst during FETCH with instr_valid=1) -> next cycle instr_valid=0, state IDLE, pc_address=RESET_PC.
